// File: rtl/mem_stage.sv
// MEM stage of the pipelined MIPS core: little-endian byte/half/word loads and stores,
// branch select, sticky fault/halt flags and a registered debug read port.
module mem_stage #(
  parameter int NB           = 32,
  parameter int NB_SIZE_TYPE = 3,
  parameter int ADDR_W       = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_step,
  input  logic [NB-1:0]           i_alu_result,
  input  logic [NB-1:0]           i_data_b_to_write,
  input  logic                    i_mem_read,
  input  logic                    i_mem_write,
  input  logic                    i_signed,
  input  logic [NB_SIZE_TYPE-1:0] i_word_size,
  input  logic                    i_branch,
  input  logic                    i_cero,
  input  logic                    i_halt,
  input  logic [ADDR_W-1:0]       i_debug_addr,
  output logic [NB-1:0]           o_read_data,
  output logic                    o_pc_src,
  output logic                    o_misaligned,
  output logic                    o_halted,
  output logic [NB-1:0]           o_debug_data
);

  localparam logic [NB_SIZE_TYPE-1:0] SIZE_BYTE = NB_SIZE_TYPE'(1);
  localparam logic [NB_SIZE_TYPE-1:0] SIZE_HALF = NB_SIZE_TYPE'(2);
  localparam logic [NB_SIZE_TYPE-1:0] SIZE_WORD = NB_SIZE_TYPE'(4);

  logic [NB-1:0]     r_mem [2**ADDR_W];
  logic [NB-1:0]     r_read_data;
  logic [NB-1:0]     r_debug_data;
  logic              r_misaligned;
  logic              r_halted;

  logic [ADDR_W-1:0] w_index;
  logic [1:0]        w_lane;
  logic              w_is_byte;
  logic              w_is_half;
  logic              w_is_word;
  logic              w_fault;
  logic              w_store;
  logic [3:0]        w_be;
  logic [NB-1:0]     w_wdata;
  logic [NB-1:0]     w_old_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [NB-1:0]     w_load_value;
  logic              w_unused;

  assign w_index    = i_alu_result[ADDR_W+1:2];
  assign w_lane     = i_alu_result[1:0];
  assign w_unused   = ^i_alu_result[NB-1:ADDR_W+2];

  assign w_is_byte  = (i_word_size == SIZE_BYTE);
  assign w_is_half  = (i_word_size == SIZE_HALF);
  assign w_is_word  = (i_word_size == SIZE_WORD);
  assign w_fault    = !(w_is_byte ||
                        (w_is_half && !w_lane[0]) ||
                        (w_is_word && (w_lane == 2'b00)));

  assign w_store    = i_step && i_mem_write && !w_fault && !r_halted && !i_reset;
  assign o_pc_src   = i_branch & i_cero;

  // Sub-word data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = i_data_b_to_write;
    if (w_is_byte) begin
      w_be    = 4'b0001 << w_lane;
      w_wdata = {4{i_data_b_to_write[7:0]}};
    end else if (w_is_half) begin
      w_be    = i_alu_result[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{i_data_b_to_write[15:0]}};
    end else if (w_is_word) begin
      w_be    = 4'b1111;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_store) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_index][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Loads read the array combinationally, so a same-edge store is seen only afterwards.
  assign w_old_word = r_mem[w_index];
  assign w_byte     = w_old_word[{w_lane, 3'b000} +: 8];
  assign w_half     = w_old_word[{i_alu_result[1], 4'b0000} +: 16];

  always_comb begin
    w_load_value = w_old_word;
    if (w_is_byte) begin
      w_load_value = {{(NB-8){i_signed & w_byte[7]}}, w_byte};
    end else if (w_is_half) begin
      w_load_value = {{(NB-16){i_signed & w_half[15]}}, w_half};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_read_data  <= '0;
      r_debug_data <= '0;
      r_misaligned <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_debug_data <= r_mem[i_debug_addr];
      if (i_step && i_mem_read) begin
        r_read_data <= w_fault ? '0 : w_load_value;
      end
      if (i_step && (i_mem_read || i_mem_write) && w_fault) begin
        r_misaligned <= 1'b1;
      end
      if (i_step && i_halt) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign o_read_data  = r_read_data;
  assign o_debug_data = r_debug_data;
  assign o_misaligned = r_misaligned;
  assign o_halted     = r_halted;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed literal cases plus randomized traffic checked every cycle
// against a byte-level memory model.
module tb_mem_stage;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset, step, memRead, memWrite, isSigned, branch, cero, halt;
  logic [2:0]  wordSize;
  logic [31:0] aluResult, storeData;
  logic [7:0]  debugAddr;
  logic [31:0] readData, debugData;
  logic        pcSrc, misaligned, halted;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mMem [DEPTH];
  bit          mKnown [DEPTH];
  logic [31:0] mRead, mDebug;
  bit          mRdValid, mDbgValid, mMis, mHalted;
  bit          mValid = 1'b0;

  always #5 clk = ~clk;

  mem_stage #(.NB(32), .NB_SIZE_TYPE(3), .ADDR_W(8)) dut (
    .i_clk(clk), .i_reset(reset), .i_step(step), .i_alu_result(aluResult),
    .i_data_b_to_write(storeData), .i_mem_read(memRead), .i_mem_write(memWrite),
    .i_signed(isSigned), .i_word_size(wordSize), .i_branch(branch), .i_cero(cero),
    .i_halt(halt), .i_debug_addr(debugAddr), .o_read_data(readData), .o_pc_src(pcSrc),
    .o_misaligned(misaligned), .o_halted(halted), .o_debug_data(debugData)
  );

  function automatic bit isFault(input logic [2:0] size, input logic [31:0] addr);
    case (size)
      3'b001:  return 1'b0;
      3'b010:  return (addr % 2) != 0;
      3'b100:  return (addr % 4) != 0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] loadValue(input logic [31:0] word, input logic [2:0] size,
                                            input logic [31:0] addr, input logic sgn);
    int unsigned lane = addr % 4;
    logic [31:0] v = word;
    if (size == 3'b001) begin
      v = (word >> (8 * lane)) & 32'hFF;
      if (sgn && v >= 128) v = v - 256;
    end else if (size == 3'b010) begin
      v = (word >> (8 * lane)) & 32'hFFFF;
      if (sgn && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic logic [31:0] storeValue(input logic [31:0] word, input logic [2:0] size,
                                             input logic [31:0] addr, input logic [31:0] data);
    int unsigned lane = addr % 4;
    logic [31:0] mask;
    if (size == 3'b001) begin
      mask = 32'hFF << (8 * lane);
      return (word & ~mask) | ((data & 32'hFF) << (8 * lane));
    end else if (size == 3'b010) begin
      mask = 32'hFFFF << (8 * lane);
      return (word & ~mask) | ((data & 32'hFFFF) << (8 * lane));
    end
    return data;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: advances once per rising edge from the inputs held over the cycle.
  always @(posedge clk) begin
    int unsigned idx;
    bit fault;
    if (reset) begin
      mRead = 0; mDebug = 0; mMis = 0; mHalted = 0;
      mRdValid = 1; mDbgValid = 1; mValid = 1;
    end else begin
      idx   = (aluResult >> 2) % DEPTH;
      fault = isFault(wordSize, aluResult);
      mDebug    = mMem[debugAddr];
      mDbgValid = mKnown[debugAddr];
      if (step && (memRead || memWrite) && fault) mMis = 1;
      if (step && memRead) begin
        if (fault) begin
          mRead = 0; mRdValid = 1;
        end else begin
          mRead = loadValue(mMem[idx], wordSize, aluResult, isSigned);
          mRdValid = mKnown[idx];
        end
      end
      if (step && memWrite && !fault && !mHalted) begin
        mMem[idx] = storeValue(mMem[idx], wordSize, aluResult, storeData);
        if (wordSize == 3'b100) mKnown[idx] = 1;
      end
      if (step && halt) mHalted = 1;
    end
  end

  always @(negedge clk) begin
    if (mValid) begin
      if (mRdValid)  checkOutput("readData", readData, mRead);
      if (mDbgValid) checkOutput("debugData", debugData, mDebug);
      checkOutput("misaligned", {31'b0, misaligned}, {31'b0, mMis});
      checkOutput("halted", {31'b0, halted}, {31'b0, mHalted});
      checkOutput("pcSrc", {31'b0, pcSrc}, {31'b0, branch & cero});
    end
  end

  task automatic applyStimulus(input logic rst, input logic stp, input logic rd, input logic wr,
                               input logic sgn, input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] data, input logic hlt);
    @(posedge clk);
    #2;
    reset = rst; step = stp; memRead = rd; memWrite = wr; isSigned = sgn;
    wordSize = size; aluResult = addr; storeData = data; halt = hlt;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic doStore(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, size, addr, data, 1'b0);
    idle();
  endtask

  // Leaves the bench at the falling edge right after the load result is registered.
  task automatic doLoad(input logic [2:0] size, input logic [31:0] addr, input logic sgn);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, sgn, size, addr, 32'h0, 1'b0);
    idle();
    @(negedge clk);
  endtask

  initial begin
    reset = 1; step = 0; memRead = 0; memWrite = 0; isSigned = 0; branch = 0; cero = 0;
    halt = 0; wordSize = 3'b100; aluResult = 0; storeData = 0; debugAddr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetReadData", readData, 32'h0);
    checkOutput("resetDebugData", debugData, 32'h0);
    checkOutput("resetMisaligned", {31'b0, misaligned}, 32'h0);
    checkOutput("resetHalted", {31'b0, halted}, 32'h0);
    idle();

    for (int i = 0; i < DEPTH; i++) begin
      debugAddr = 8'($urandom_range(0, DEPTH - 1));
      doStore(3'b100, 32'(i * 4), $urandom());
    end

    debugAddr = 8'd4;
    doStore(3'b100, 32'h10, 32'hDEADBEEF);
    doLoad(3'b100, 32'h10, 1'b0);
    checkOutput("wordRoundTrip", readData, 32'hDEADBEEF);
    checkOutput("debugRoundTrip", debugData, 32'hDEADBEEF);

    doStore(3'b001, 32'h11, 32'hAABBCC55);
    doLoad(3'b100, 32'h10, 1'b0);
    checkOutput("byteStoreLane1", readData, 32'hDEAD55EF);
    doLoad(3'b001, 32'h13, 1'b1);
    checkOutput("byteLoadSigned", readData, 32'hFFFFFFDE);
    doLoad(3'b001, 32'h13, 1'b0);
    checkOutput("byteLoadUnsigned", readData, 32'h000000DE);
    doLoad(3'b010, 32'h12, 1'b1);
    checkOutput("halfLoadSigned", readData, 32'hFFFFDEAD);

    checkOutput("misalignedBefore", {31'b0, misaligned}, 32'h0);
    doStore(3'b100, 32'h20, 32'h11223344);
    doStore(3'b100, 32'h22, 32'hCAFEF00D);
    doLoad(3'b100, 32'h20, 1'b0);
    checkOutput("misalignedStoreSuppressed", readData, 32'h11223344);
    checkOutput("misalignedSticky", {31'b0, misaligned}, 32'h1);

    doStore(3'b100, 32'h30, 32'h7);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 32'h30, 32'h99, 1'b0);
    idle();
    doLoad(3'b100, 32'h30, 1'b0);
    checkOutput("noStepNoStore", readData, 32'h7);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 32'h30, 32'h1, 1'b0);
    idle();
    @(negedge clk);
    checkOutput("readFirst", readData, 32'h7);
    doLoad(3'b100, 32'h30, 1'b0);
    checkOutput("afterReadFirst", readData, 32'h1);

    branch = 1; cero = 1;
    #1 checkOutput("pcSrcTaken", {31'b0, pcSrc}, 32'h1);
    cero = 0;
    #1 checkOutput("pcSrcNotTaken", {31'b0, pcSrc}, 32'h0);
    branch = 0;

    doStore(3'b100, 32'h40, 32'h0BADF00D);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 32'h0, 32'h0, 1'b1);
    idle();
    @(negedge clk);
    checkOutput("haltSet", {31'b0, halted}, 32'h1);
    doStore(3'b100, 32'h30, 32'h5);
    doLoad(3'b100, 32'h30, 1'b0);
    checkOutput("haltBlocksStore", readData, 32'h1);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 32'h40, 32'hAAAAAAAA, 1'b0);
    idle();
    @(negedge clk);
    checkOutput("midResetReadData", readData, 32'h0);
    checkOutput("midResetDebugData", debugData, 32'h0);
    checkOutput("midResetMisaligned", {31'b0, misaligned}, 32'h0);
    checkOutput("midResetHalted", {31'b0, halted}, 32'h0);
    doLoad(3'b100, 32'h40, 1'b0);
    checkOutput("resetStoreSuppressed", readData, 32'h0BADF00D);

    debugAddr = 8'd0;
    doStore(3'b100, 32'h400, 32'h600DCAFE);
    doLoad(3'b100, 32'h0, 1'b0);
    checkOutput("wrapLoad", readData, 32'h600DCAFE);
    checkOutput("wrapDebug", debugData, 32'h600DCAFE);

    for (int n = 0; n < 3000; n++) begin
      logic [2:0]  sz;
      logic [31:0] addr;
      int          pick;
      pick = $urandom_range(0, 9);
      if (pick < 3)      sz = 3'b001;
      else if (pick < 6) sz = 3'b010;
      else if (pick < 9) sz = 3'b100;
      else               sz = 3'($urandom_range(5, 7));
      addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) addr = addr | ($urandom() & 32'hFFFFFC00);
      applyStimulus(1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    sz, addr, $urandom(), 1'($urandom_range(0, 59) == 0));
      debugAddr = 8'($urandom_range(0, 255));
      branch    = 1'($urandom_range(0, 1));
      cero      = 1'($urandom_range(0, 1));
    end

    idle();
    idle();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
